// File: rtl/irq_conditioner_pkg.sv
// irq_conditioner_pkg: shared constants for the external interrupt front end and its register map
package irq_conditioner_pkg;
  localparam int IRQ_COUNT = 32;
  localparam logic [1:0] REG_MODE = 2'd0;
  localparam logic [1:0] REG_POL = 2'd1;
  localparam logic [1:0] REG_EN = 2'd2;
  localparam logic [1:0] REG_RAW = 2'd3;
  localparam logic [31:0] VECTOR_BASE = 32'hfffff000;
  localparam logic [31:0] STACK_BASE = 32'hfffff800;
  localparam logic [31:0] TRAMPOLINE_BASE = 32'hfffffc00;
  localparam logic [31:0] CFG_BASE_DEFAULT = 32'hffffe000;
endpackage

// File: rtl/irq_conditioner_if.sv
// irq_conditioner_if: core data bus control signals (strobe/rw/word address)
interface irq_conditioner_if;
  logic strobe;
  logic rw;
  logic [31:0] d_addr;
  modport master (output strobe, rw, d_addr);
  modport slave (input strobe, rw, d_addr);
endinterface

// File: rtl/irq_conditioner_line.sv
// irq_line: one interrupt line: synchroniser, optional debounce (IRQ_DEBOUNCE_EN), history and active-term logic
module irq_line #(
  parameter int SYNC_STAGES = 2
`ifdef IRQ_DEBOUNCE_EN
  , parameter int DEBOUNCE_BITS = 4
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ext_i,
  input  logic mode_i,
  input  logic pol_i,
  output logic f_o,
  output logic cond_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic s;
  logic h_q;
  always_ff @(posedge clk)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], ext_i};
  assign s = sync_q[SYNC_STAGES-1];
`ifdef IRQ_DEBOUNCE_EN
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic f_q, f_d;
  // f follows s only after 2^DEBOUNCE_BITS-1 consecutive disagreeing samples
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    f_d = (s != f_q && &cnt_inc) ? s : f_q;
    cnt_d = (s == f_q || &cnt_inc) ? '0 : cnt_inc;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      cnt_q <= '0;
      f_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      f_q <= f_d;
    end
  assign f_o = f_q;
`else
  assign f_o = s;
`endif
  // history tracks the raw (unpolarised) value so POL changes never look like edges
  always_ff @(posedge clk)
    if (!reset_n) h_q <= 1'b0;
    else h_q <= f_o;
  assign cond_o = mode_i ? (pol_i ? (h_q & ~f_o) : (~h_q & f_o)) : (f_o ^ pol_i);
endmodule

// File: rtl/irq_conditioner.sv
// irq_conditioner: conditions external interrupt lines for the interrupt controller; optional debounce via IRQ_DEBOUNCE_EN
module irq_conditioner
  import irq_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter logic [31:0] CFG_BASE = CFG_BASE_DEFAULT
`ifdef IRQ_DEBOUNCE_EN
  , parameter int DEBOUNCE_BITS = 4
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [IRQ_COUNT-1:0] ext_irq_i,
  irq_conditioner_if.slave bus,
  inout  wire [31:0] d_data_io,
  output logic [IRQ_COUNT-1:0] irq_o
);
  logic [IRQ_COUNT-1:0] mode_q, mode_d, pol_q, pol_d, en_q, en_d, irq_q, irq_d, f, cond;
  logic [31:0] rd_q, rd_d;
  logic sel, wr, rd;
  for (genvar i = 0; i < IRQ_COUNT; i++) begin : g_line
    irq_line #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef IRQ_DEBOUNCE_EN
      , .DEBOUNCE_BITS(DEBOUNCE_BITS)
`endif
    ) u_line (
      .clk(clk),
      .reset_n(reset_n),
      .ext_i(ext_irq_i[i]),
      .mode_i(mode_q[i]),
      .pol_i(pol_q[i]),
      .f_o(f[i]),
      .cond_o(cond[i])
    );
  end
  always_comb begin
    sel = bus.strobe && bus.d_addr[31:2] == CFG_BASE[31:2];
    wr = sel && bus.rw;
    rd = sel && !bus.rw;
    mode_d = (wr && bus.d_addr[1:0] == REG_MODE) ? d_data_io : mode_q;
    pol_d = (wr && bus.d_addr[1:0] == REG_POL) ? d_data_io : pol_q;
    en_d = (wr && bus.d_addr[1:0] == REG_EN) ? d_data_io : en_q;
    rd_d = !rd ? rd_q :
           bus.d_addr[1:0] == REG_MODE ? mode_q :
           bus.d_addr[1:0] == REG_POL ? pol_q :
           bus.d_addr[1:0] == REG_EN ? en_q : f;
    irq_d = en_q & cond;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      mode_q <= '0;
      pol_q <= '0;
      en_q <= '0;
      rd_q <= '0;
      irq_q <= '0;
    end else begin
      mode_q <= mode_d;
      pol_q <= pol_d;
      en_q <= en_d;
      rd_q <= rd_d;
      irq_q <= irq_d;
    end
  assign d_data_io = (rd && reset_n) ? rd_q : 'z;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_irq_conditioner.sv
// tb_irq_conditioner: directed and table-driven checks of the interrupt conditioner
module tb_irq_conditioner;
  import irq_conditioner_pkg::*;
  localparam logic [31:0] BASE = CFG_BASE_DEFAULT;
  typedef struct {
    logic [3:0] ext_n;
    logic [3:0] irq_n;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] ext = '0;
  logic [31:0] irq;
  logic tb_drv = 1'b0;
  logic [31:0] tb_wd = '0;
  wire [31:0] d_data;
  int checks = 0;
  int errors = 0;
  irq_conditioner_if bus();
  assign d_data = tb_drv ? tb_wd : 'z;
  irq_conditioner dut (
    .clk(clk),
    .reset_n(reset_n),
    .ext_irq_i(ext),
    .bus(bus),
    .d_data_io(d_data),
    .irq_o(irq)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] v);
    bus.strobe = 1'b1;
    bus.rw = 1'b1;
    bus.d_addr = BASE + 32'(off);
    tb_drv = 1'b1;
    tb_wd = v;
    tick();
    bus.strobe = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] v);
    bus.strobe = 1'b1;
    bus.rw = 1'b0;
    bus.d_addr = BASE + 32'(off);
    tick();
    v = d_data;
    bus.strobe = 1'b0;
  endtask

  // drive line b high for hi steps out of total, counting irq[b] pulses and the step of the first one
  task automatic run(input int b, input int hi, input int total, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int k = 0; k < total; k++) begin
      ext[b] = (k < hi);
      tick();
      if (irq[b]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  initial begin
    logic [31:0] v, acc;
    int c, f;
    vec_t tbl[10];
    tbl[0] = '{4'hF, 4'h2};
    tbl[1] = '{4'h9, 4'h2};
    tbl[2] = '{4'h4, 4'h5};
    tbl[3] = '{4'hA, 4'h3};
    tbl[4] = '{4'h7, 4'hE};
    tbl[5] = '{4'hC, 4'h0};
    tbl[6] = '{4'h5, 4'hD};
    tbl[7] = '{4'h1, 4'h2};
    tbl[8] = '{4'h2, 4'hB};
    tbl[9] = '{4'h0, 4'h3};
    bus.strobe = 1'b0;
    bus.rw = 1'b0;
    bus.d_addr = '0;
    tick();
    tick();
    chk("reset_irq", irq, 32'h0);
    reset_n = 1'b1;
    ext = '1;
    acc = '0;
    repeat (20) begin
      tick();
      acc |= irq;
    end
    chk("quiet_after_reset", acc, 32'h0);
    rd(REG_RAW, v);
    chk("raw_ones", v, 32'hffffffff);
    for (int r = 0; r < 3; r++) begin
      rd(2'(r), v);
      chk($sformatf("reset_reg%0d", r), v, 32'h0);
    end
`ifdef IRQ_DEBOUNCE_EN
    ext = '0;
    wr(REG_MODE, 32'h1);
    wr(REG_EN, 32'h1);
    rd(REG_MODE, v);
    chk("mode_readback", v, 32'h1);
    rd(REG_EN, v);
    chk("en_readback", v, 32'h1);
    repeat (25) tick();
    run(0, 10, 40, c, f);
    chk("glitch_count", 32'(c), 32'd0);
    run(0, 20, 40, c, f);
    chk("debounce_count", 32'(c), 32'd1);
    chk("debounce_at", 32'(f), 32'd17);
    chk("debounce_idle", irq, 32'h0);
`else
    ext = '0;
    wr(REG_EN, 32'h8);
    wr(REG_MODE, 32'h0);
    wr(REG_POL, 32'h0);
    repeat (4) tick();
    ext[3] = 1'b1;
    tick();
    tick();
    chk("lvl_rise_early", 32'(irq[3]), 32'd0);
    tick();
    chk("lvl_rise", 32'(irq[3]), 32'd1);
    repeat (5) tick();
    chk("lvl_hold", irq, 32'h8);
    ext[3] = 1'b0;
    tick();
    tick();
    chk("lvl_fall_early", 32'(irq[3]), 32'd1);
    tick();
    chk("lvl_fall", 32'(irq[3]), 32'd0);
    wr(REG_MODE, 32'h20);
    wr(REG_EN, 32'h20);
    repeat (4) tick();
    run(5, 10, 16, c, f);
    chk("rise_count", 32'(c), 32'd1);
    chk("rise_at", 32'(f), 32'd2);
    wr(REG_POL, 32'h20);
    acc = irq;
    repeat (5) begin
      tick();
      acc |= irq;
    end
    chk("pol_write_quiet", acc, 32'h0);
    run(5, 10, 16, c, f);
    chk("fall_count", 32'(c), 32'd1);
    chk("fall_at", 32'(f), 32'd12);
    wr(REG_POL, 32'h0);
    wr(REG_MODE, 32'h80);
    wr(REG_EN, 32'h0);
    ext[7] = 1'b1;
    repeat (5) tick();
    wr(REG_EN, 32'h80);
    acc = irq;
    repeat (6) begin
      tick();
      acc |= irq;
    end
    chk("enable_no_stale", acc, 32'h0);
    ext[7] = 1'b0;
    acc = '0;
    repeat (5) begin
      tick();
      acc |= irq;
    end
    chk("fall_in_rise_mode", acc, 32'h0);
    run(7, 20, 20, c, f);
    chk("reenable_count", 32'(c), 32'd1);
    chk("reenable_at", 32'(f), 32'd2);
    wr(REG_EN, 32'h0);
    wr(REG_MODE, 32'h20);
    wr(REG_EN, 32'h20);
    ext = '0;
    repeat (4) tick();
    ext[5] = 1'b1;
    tick();
    tick();
    wr(REG_EN, 32'h0);
    chk("write_same_cycle", 32'(irq[5]), 32'd1);
    tick();
    chk("write_same_cycle_end", 32'(irq[5]), 32'd0);
    ext = '0;
    wr(REG_MODE, 32'h60);
    wr(REG_POL, 32'h50);
    wr(REG_EN, 32'h78);
    rd(REG_POL, v);
    chk("pol_readback", v, 32'h50);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      ext = {i[0], 24'b0, tbl[i].ext_n, 3'b0};
      tick();
      chk($sformatf("vec%0d", i), irq, {25'b0, tbl[i].irq_n, 3'b0});
    end
    ext = 32'h4;
    wr(REG_MODE, 32'h0);
    wr(REG_POL, 32'h0);
    wr(REG_EN, 32'h4);
    bus.strobe = 1'b1;
    bus.rw = 1'b1;
    bus.d_addr = BASE + 32'd4;
    tb_drv = 1'b1;
    tb_wd = '1;
    tick();
    bus.strobe = 1'b0;
    bus.d_addr = BASE + 32'(REG_EN);
    tick();
    tb_drv = 1'b0;
    rd(REG_EN, v);
    chk("stray_writes_ignored", v, 32'h4);
    wr(REG_RAW, 32'h0);
    rd(REG_RAW, v);
    chk("raw_read_only", v, 32'h4);
    repeat (2) tick();
    chk("lvl2_active", irq, 32'h4);
    reset_n = 1'b0;
    tick();
    chk("reset_mid_pulse", irq, 32'h0);
    reset_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rd(2'(r), v);
      chk($sformatf("post_reset_reg%0d", r), v, 32'h0);
    end
    repeat (4) tick();
    chk("post_reset_quiet", irq, 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
